memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Fourth pipeline stage. Consumes the execute-stage result bundle: operation code, ALU result/effective address, store data, rd.
- Performs load/store accesses to data memory over a valid/ready request plus response-valid handshake. Handles byte-lane alignment and sign/zero extension, and detects misalignment.
- Presents a registered bundle to writeback. Stalls execute while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, data-memory byte address width.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- ex_valid  in  1  execute bundle valid.
- ex_alu_operation  in  6  ALU operation code (shared ISA encoding).
- ex_alu_result  in  XLEN  ALU result; effective address for loads/stores.
- ex_store_data  in  XLEN  rs2 value for stores.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_ready  out  1  stage can accept a bundle this cycle.
- dmem_req  out  1  request valid.
- dmem_ready  in  1  memory accepts request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dmem_wstrb  out  4  byte write strobes.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load word.
- wb_valid  out  1  writeback bundle valid (one-cycle pulse per instruction).
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  value to write.
- wb_reg_write  out  1  write enable to register file.
- wb_misaligned  out  1  access was misaligned; rd is not written.

Behaviour:
- Reset: state IDLE. wb_valid, wb_reg_write, wb_misaligned, dmem_req and dmem_we are 0. wb_rd, wb_data, dmem_addr, dmem_wstrb and dmem_wdata are 0. ex_ready is 1.
- FSM states: IDLE, REQ, WAIT. ex_ready = (state==IDLE).
- IDLE, ex_valid, non-memory op: next cycle wb_valid=1 with wb_data=ex_alu_result and wb_reg_write=ex_reg_write. Latency is 1; back-to-back bundles are accepted every cycle.
- IDLE, ex_valid, load/store, aligned: latch op, byte offset, rd and data, then go to REQ. dmem_req is registered and asserts the next cycle.
- Misalignment check:
  - LH/LHU/SH are misaligned when addr[0]=1.
  - LW/SW are misaligned when addr[1:0]!=0.
  - A misaligned access issues no request.
  - Next cycle: wb_valid=1, wb_misaligned=1, wb_reg_write=0, wb_data=address. Stay in IDLE.
- REQ: hold dmem_req and all request fields stable until dmem_ready.
  - On dmem_req && dmem_ready, a store goes to IDLE and pulses wb_valid with wb_reg_write=0 the next cycle.
  - On dmem_req && dmem_ready, a load goes to WAIT.
- WAIT: on dmem_rvalid, extract the lane at the latched offset and extend. The next cycle pulses wb_valid with wb_reg_write=ex_reg_write latched. Return to IDLE.
- Minimum latencies, with memory ready/rvalid asserted immediately:
  - store: 2 cycles from acceptance to wb_valid.
  - load: 3 cycles from acceptance to wb_valid.
- Store lanes:
  - SB: wstrb=1<<off; wdata=replicated byte.
  - SH: wstrb=3<<off; wdata=replicated halfword.
  - SW: wstrb=4'hF.
- Load extraction:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rvalid outside WAIT is ignored. dmem_ready while dmem_req=0 has no effect.
- wb_rd is always the rd latched for the completing instruction.
- Synchronous reset in REQ/WAIT abandons the access: dmem_req drops on the next edge, and no wb_valid is issued for it.
- x0 handling is downstream; the stage passes rd unmodified.

Decomposition:
- Memory operation codes and stage state enum go in the shared ISA header/package. The existing load/store operation macros are reused; no new opcodes are defined.
- One sub-module, load_aligner: combinational lane select plus sign/zero extension for loads. The FSM, store lane formatting and misalignment check stay in memory_stage.

Test Plan:
- ADD bundle with alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, ex_ready stays 1.
- SB at addr 0x103 with store_data=0xAB -> dmem_addr=0x100, wstrb=4'b1000, wdata=0xABAB_ABAB. With dmem_ready delayed 3 cycles, req/fields stay stable and ex_ready=0. wb_valid follows with wb_reg_write=0.
- LB at addr 0x202 with rdata=0x1280_3456 -> wb_data=0xFFFF_FF80. LBU at the same address -> wb_data=0x0000_0080.
- LH at addr 0x006 with rdata=0x8001_0000 -> wb_data=0xFFFF_8001. LW at 0x005 -> no dmem_req, wb_misaligned=1, wb_reg_write=0, wb_data=0x5.
- Load with rvalid delayed 4 cycles and reset asserted in WAIT -> dmem_req=0 and wb_valid=0 after reset, state IDLE, ex_ready=1. A subsequent ADD completes normally.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared ISA constants for the memory stage: operation codes, FSM state
// encodings and small helpers that classify loads and stores.
package memory_stage_pkg;

    typedef logic [5:0] op_t;

    // Non-memory operations. The stage only forwards their ALU result.
    localparam op_t OP_ADD = 6'h00;
    localparam op_t OP_SUB = 6'h01;
    localparam op_t OP_XOR = 6'h04;

    // Loads
    localparam op_t OP_LB  = 6'h10;
    localparam op_t OP_LH  = 6'h11;
    localparam op_t OP_LW  = 6'h12;
    localparam op_t OP_LBU = 6'h13;
    localparam op_t OP_LHU = 6'h14;

    // Stores
    localparam op_t OP_SB  = 6'h18;
    localparam op_t OP_SH  = 6'h19;
    localparam op_t OP_SW  = 6'h1A;

    // Stage FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic is_load(input op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfword accesses need an even address, word accesses a multiple of four.
    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) begin
            mis = off[0];
        end else if ((op == OP_LW) || (op == OP_SW)) begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_load_aligner.sv
// Load data aligner: picks the addressed byte/halfword out of the returned
// memory word and sign- or zero-extends it to XLEN.
module load_aligner
    import memory_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    // Move the addressed lane down to bit 0, then extend according to the op.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        data_o  = shifted;
        case (op_i)
            OP_LB:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            OP_LBU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            OP_LH:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            OP_LHU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: forwards non-memory results, issues aligned
// load/store requests to data memory, formats store lanes, flags misaligned
// accesses and presents a registered one-cycle writeback bundle.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [5:0]            ex_alu_operation,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_write,
    output logic                  ex_ready,
    output logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_wstrb,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_reg_write,
    output logic                  wb_misaligned
);

    logic [1:0]            state_q, state_d;
    logic [5:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            rd_q, rd_d;
    logic                  regWrite_q, regWrite_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  wbValid_q, wbValid_d;
    logic [4:0]            wbRd_q, wbRd_d;
    logic [XLEN-1:0]       wbData_q, wbData_d;
    logic                  wbRegWrite_q, wbRegWrite_d;
    logic                  wbMis_q, wbMis_d;

    logic [3:0]            storeStrb;
    logic [XLEN-1:0]       storeData;
    logic [XLEN-1:0]       loadData;

    load_aligner #(.XLEN(XLEN)) u_load_aligner (
        .op_i     (op_q),
        .offset_i (off_q),
        .rdata_i  (dmem_rdata),
        .data_o   (loadData)
    );

    // Store lane formatting: replicate the datum across the word and strobe only the addressed bytes.
    always_comb begin
        storeStrb = 4'hF;
        storeData = ex_store_data;
        case (ex_alu_operation)
            OP_SB: begin
                storeStrb = 4'b0001 << ex_alu_result[1:0];
                storeData = {(XLEN/8){ex_store_data[7:0]}};
            end
            OP_SH: begin
                storeStrb = 4'b0011 << ex_alu_result[1:0];
                storeData = {(XLEN/16){ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state logic for the IDLE/REQ/WAIT access FSM and the writeback bundle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rd_d         = rd_q;
        regWrite_d   = regWrite_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        wbValid_d    = 1'b0;
        wbRd_d       = wbRd_q;
        wbData_d     = wbData_q;
        wbRegWrite_d = wbRegWrite_q;
        wbMis_d      = wbMis_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_load(ex_alu_operation) || is_store(ex_alu_operation)) begin
                        if (is_misaligned(ex_alu_operation, ex_alu_result[1:0])) begin
                            wbValid_d    = 1'b1;
                            wbRd_d       = ex_rd;
                            wbData_d     = ex_alu_result;
                            wbRegWrite_d = 1'b0;
                            wbMis_d      = 1'b1;
                        end else begin
                            op_d       = ex_alu_operation;
                            off_d      = ex_alu_result[1:0];
                            rd_d       = ex_rd;
                            regWrite_d = ex_reg_write;
                            req_d      = 1'b1;
                            we_d       = is_store(ex_alu_operation);
                            addr_d     = {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
                            wstrb_d    = is_store(ex_alu_operation) ? storeStrb : 4'b0000;
                            wdata_d    = is_store(ex_alu_operation) ? storeData : '0;
                            state_d    = ST_REQ;
                        end
                    end else begin
                        wbValid_d    = 1'b1;
                        wbRd_d       = ex_rd;
                        wbData_d     = ex_alu_result;
                        wbRegWrite_d = ex_reg_write;
                        wbMis_d      = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (is_store(op_q)) begin
                        wbValid_d    = 1'b1;
                        wbRd_d       = rd_q;
                        wbRegWrite_d = 1'b0;
                        wbMis_d      = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    wbValid_d    = 1'b1;
                    wbRd_d       = rd_q;
                    wbData_d     = loadData;
                    wbRegWrite_d = regWrite_q;
                    wbMis_d      = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            regWrite_q   <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            wbValid_q    <= 1'b0;
            wbRd_q       <= '0;
            wbData_q     <= '0;
            wbRegWrite_q <= 1'b0;
            wbMis_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            regWrite_q   <= regWrite_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            wbValid_q    <= wbValid_d;
            wbRd_q       <= wbRd_d;
            wbData_q     <= wbData_d;
            wbRegWrite_q <= wbRegWrite_d;
            wbMis_q      <= wbMis_d;
        end
    end

    assign ex_ready      = (state_q == ST_IDLE);
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wstrb    = wstrb_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wbValid_q;
    assign wb_rd         = wbRd_q;
    assign wb_data       = wbData_q;
    assign wb_reg_write  = wbRegWrite_q;
    assign wb_misaligned = wbMis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table-driven single-instruction vectors with a
// writeback scoreboard, plus hand sequences for back-to-back issue and reset
// during an outstanding access.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [5:0]  ex_alu_operation;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        wb_misaligned;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chkData;
        logic        rw;
        logic        mis;
    } sb_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        int          readyDly;
        int          rvalidDly;
        logic [31:0] rdata;
        logic        expReq;
        logic        expWe;
        logic [31:0] expAddr;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        logic [31:0] expData;
        logic        chkData;
        logic        expRw;
        logic        expMis;
    } vec_t;

    sb_t  sbQ[$];
    vec_t vecs[$];

    memory_stage #(.ADDR_WIDTH(32), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_alu_operation (ex_alu_operation),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_ready         (ex_ready),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_wdata       (dmem_wdata),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .wb_reg_write     (wb_reg_write),
        .wb_misaligned    (wb_misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Writeback monitor: every wb_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb actual=wb_valid=1 required=no writeback");
            end else begin
                sb_t e;
                e = sbQ.pop_front();
                checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                if (e.chkData) checkOutput("wb_data", wb_data, e.data);
                checkOutput("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                checkOutput("wb_misaligned", {31'd0, wb_misaligned}, {31'd0, e.mis});
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wb_timeout actual=%0d pending required=0 pending", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic driveBundle(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [4:0] rd, input logic rw);
        ex_valid         = 1'b1;
        ex_alu_operation = op;
        ex_alu_result    = addr;
        ex_store_data    = sdata;
        ex_rd            = rd;
        ex_reg_write     = rw;
    endtask

    task automatic applyStimulus(input vec_t v);
        sb_t e;
        @(posedge clk); #1;
        checkOutput("ex_ready_idle", {31'd0, ex_ready}, 32'd1);
        driveBundle(v.op, v.addr, v.sdata, v.rd, v.rw);
        e.rd = v.rd; e.data = v.expData; e.chkData = v.chkData; e.rw = v.expRw; e.mis = v.expMis;
        sbQ.push_back(e);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        checkOutput("dmem_req", {31'd0, dmem_req}, {31'd0, v.expReq});
        if (v.expReq) begin
            for (int d = 0; d <= v.readyDly; d++) begin
                checkOutput("req_held", {31'd0, dmem_req}, 32'd1);
                checkOutput("ex_ready_busy", {31'd0, ex_ready}, 32'd0);
                checkOutput("dmem_addr", dmem_addr, v.expAddr);
                checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, v.expWe});
                if (v.expWe) begin
                    checkOutput("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, v.expStrb});
                    checkOutput("dmem_wdata", dmem_wdata, v.expWdata);
                end
                dmem_ready = (d == v.readyDly);
                @(posedge clk); #1;
            end
            dmem_ready = 1'b0;
            checkOutput("req_dropped", {31'd0, dmem_req}, 32'd0);
            if (!v.expWe) begin
                repeat (v.rvalidDly) begin
                    @(posedge clk); #1;
                end
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
                dmem_rdata  = 32'hDEAD_0000;
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_alu_operation = OP_ADD; ex_alu_result = '0;
        ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        //             op      addr          sdata         rd  rw rdy rv rdata         req we  expAddr       strb     wdata          data          chk rw mis
        vecs.push_back('{OP_ADD, 32'h0000_1234, 32'h0,       5'd5,  1, 0, 0, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_1234, 1, 1, 0});
        vecs.push_back('{OP_SB,  32'h0000_0103, 32'h0000_00AB, 5'd7, 1, 3, 0, 32'h0,       1, 1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0,        0, 0, 0});
        vecs.push_back('{OP_LB,  32'h0000_0202, 32'h0,       5'd10, 1, 0, 0, 32'h1280_3456, 1, 0, 32'h0000_0200, 4'h0,    32'h0,        32'hFFFF_FF80, 1, 1, 0});
        vecs.push_back('{OP_LBU, 32'h0000_0202, 32'h0,       5'd11, 1, 0, 0, 32'h1280_3456, 1, 0, 32'h0000_0200, 4'h0,    32'h0,        32'h0000_0080, 1, 1, 0});
        vecs.push_back('{OP_LH,  32'h0000_0006, 32'h0,       5'd12, 1, 0, 0, 32'h8001_0000, 1, 0, 32'h0000_0004, 4'h0,    32'h0,        32'hFFFF_8001, 1, 1, 0});
        vecs.push_back('{OP_LW,  32'h0000_0005, 32'h0,       5'd9,  1, 0, 0, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_0005, 1, 0, 1});
        vecs.push_back('{OP_SH,  32'h0000_0102, 32'h1234_BEEF, 5'd1, 0, 1, 0, 32'h0,       1, 1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 0});
        vecs.push_back('{OP_SW,  32'h0000_010C, 32'hDEAD_BEEF, 5'd2, 0, 0, 0, 32'h0,       1, 1, 32'h0000_010C, 4'hF,    32'hDEAD_BEEF, 32'h0,        0, 0, 0});
        vecs.push_back('{OP_LHU, 32'h0000_000A, 32'h0,       5'd13, 1, 0, 2, 32'hF00D_0000, 1, 0, 32'h0000_0008, 4'h0,    32'h0,        32'h0000_F00D, 1, 1, 0});
        vecs.push_back('{OP_LH,  32'h0000_0003, 32'h0,       5'd14, 1, 0, 0, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_0003, 1, 0, 1});
        vecs.push_back('{OP_SH,  32'h0000_0001, 32'h0000_5555, 5'd15, 1, 0, 0, 32'h0,      0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_0001, 1, 0, 1});
        vecs.push_back('{OP_LW,  32'h0000_0008, 32'h0,       5'd16, 0, 0, 1, 32'h89AB_CDEF, 1, 0, 32'h0000_0008, 4'h0,    32'h0,        32'h89AB_CDEF, 1, 0, 0});
        vecs.push_back('{OP_LB,  32'h0000_0001, 32'h0,       5'd17, 1, 0, 0, 32'h0000_7F00, 1, 0, 32'h0000_0000, 4'h0,    32'h0,        32'h0000_007F, 1, 1, 0});
        vecs.push_back('{OP_SB,  32'h0000_0000, 32'h0000_0055, 5'd18, 0, 0, 0, 32'h0,      1, 1, 32'h0000_0000, 4'b0001, 32'h5555_5555, 32'h0,        0, 0, 0});
        vecs.push_back('{OP_XOR, 32'hFFFF_0000, 32'h0,       5'd31, 0, 0, 0, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0,        32'hFFFF_0000, 1, 0, 0});
        vecs.push_back('{OP_LB,  32'h0000_0003, 32'h0,       5'd19, 1, 0, 0, 32'hC000_0000, 1, 0, 32'h0000_0000, 4'h0,    32'h0,        32'hFFFF_FFC0, 1, 1, 0});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        checkOutput("rst_wb_misaligned", {31'd0, wb_misaligned}, 32'd0);
        checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
        checkOutput("rst_dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
        checkOutput("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        reset = 1'b0;

        // dmem_ready with no request outstanding must do nothing
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        checkOutput("idle_ready_ignored", {31'd0, dmem_req}, 32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Back-to-back non-memory bundles, one per cycle
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            sb_t e;
            checkOutput("b2b_ex_ready", {31'd0, ex_ready}, 32'd1);
            driveBundle(OP_ADD, 32'h0000_1000 + k, 32'h0, 5'(20 + k), 1'b1);
            e.rd = 5'(20 + k); e.data = 32'h0000_1000 + k; e.chkData = 1'b1; e.rw = 1'b1; e.mis = 1'b0;
            sbQ.push_back(e);
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        drain();

        // Reset while waiting for load data abandons the load
        @(posedge clk); #1;
        driveBundle(OP_LW, 32'h0000_0300, 32'h0, 5'd3, 1'b1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        checkOutput("rstwait_req", {31'd0, dmem_req}, 32'd1);
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        checkOutput("rstwait_busy", {31'd0, ex_ready}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstwait_req_after", {31'd0, dmem_req}, 32'd0);
        checkOutput("rstwait_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rstwait_ex_ready", {31'd0, ex_ready}, 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        checkOutput("stale_rvalid_ignored", {31'd0, wb_valid}, 32'd0);
        applyStimulus(vecs[0]);

        // Reset while a request is outstanding drops the request
        @(posedge clk); #1;
        driveBundle(OP_SW, 32'h0000_0400, 32'h0BAD_F00D, 5'd4, 1'b0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        checkOutput("rstreq_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstreq_req_after", {31'd0, dmem_req}, 32'd0);
        checkOutput("rstreq_ex_ready", {31'd0, ex_ready}, 32'd1);
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        checkOutput("rstreq_no_wb", {31'd0, wb_valid}, 32'd0);
        applyStimulus(vecs[14]);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
